cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.

---
 rtl/cla_pipe_adder.sv | 131 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Groups of GROUP bits are split evenly over STAGES registers; the group carry ripples stage to stage.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic                     out_zero,
  output logic [WIDTH/GROUP-1:0]   out_gc
);

  localparam int unsigned NGRP = WIDTH / GROUP;
  localparam int unsigned NPS  = NGRP / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Each stage register carries the full operands plus the partial sum; upper
  // operand bits and the lower finished sum bits pass through untouched.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             cmsb;
    logic             zero;
    logic [NGRP-1:0]  gc;
  } stage_t;

  stage_t stg_q   [STAGES];
  stage_t stg_d   [STAGES];
  stage_t stg_in  [STAGES];
  logic   rdy     [STAGES];

  function automatic stage_t stage_fn(input stage_t si, input int unsigned s);
    stage_t          so;
    logic            c;
    logic            gg;
    logic            pg;
    logic [GROUP-1:0] gv;
    logic [GROUP-1:0] pv;
    logic [GROUP-1:0] cv;
    int unsigned     grp;
    int unsigned     idx;
    so = si;
    c  = si.carry;
    for (int unsigned k = 0; k < NPS; k++) begin
      grp = s * NPS + k;
      for (int unsigned j = 0; j < GROUP; j++) begin
        idx   = grp * GROUP + j;
        gv[j] = si.a[idx] & si.b[idx];
        pv[j] = si.a[idx] ^ si.b[idx];
      end
      cv[0] = c;
      for (int unsigned j = 1; j < GROUP; j++)
        cv[j] = gv[j-1] | (pv[j-1] & cv[j-1]);
      gg = 1'b0;
      pg = 1'b1;
      for (int unsigned j = 0; j < GROUP; j++) begin
        gg = gv[j] | (pv[j] & gg);
        pg = pg & pv[j];
      end
      for (int unsigned j = 0; j < GROUP; j++)
        so.sum[grp * GROUP + j] = pv[j] ^ cv[j];
      c = gg | (pg & c);
      so.gc[grp] = c;
      if (grp == NGRP - 1)
        so.cmsb = cv[GROUP-1];
    end
    so.carry = c;
    if (s == LAST)
      so.zero = ~|so.sum;
    return so;
  endfunction

  always_comb begin
    stg_in[0]       = '0;
    stg_in[0].valid = in_valid;
    stg_in[0].a     = in_a;
    stg_in[0].b     = in_sub ? ~in_b : in_b;
    stg_in[0].carry = in_sub ? 1'b1 : in_cin;
    for (int unsigned s = 1; s < STAGES; s++)
      stg_in[s] = stg_q[s-1];

    // Bubble-collapsing ready chain, evaluated from the output backwards.
    rdy[LAST] = ~stg_q[LAST].valid | out_ready;
    for (int unsigned k = 1; k < STAGES; k++)
      rdy[LAST-k] = ~stg_q[LAST-k].valid | rdy[LAST-k+1];

    for (int unsigned s = 0; s < STAGES; s++) begin
      stg_d[s] = stg_q[s];
      if (rdy[s]) begin
        if (stg_in[s].valid)
          stg_d[s] = stage_fn(stg_in[s], s);
        else
          stg_d[s].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++)
        stg_q[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++)
        stg_q[s] <= stg_d[s];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg_q[LAST].valid;
  assign out_sum   = stg_q[LAST].sum;
  assign out_cout  = stg_q[LAST].carry;
  assign out_ovf   = stg_q[LAST].cmsb ^ stg_q[LAST].carry;
  assign out_zero  = stg_q[LAST].zero;
  assign out_gc    = stg_q[LAST].gc;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes expected results, a negedge monitor pops and compares.
module tb_cla_pipe_adder;

  localparam int unsigned W  = 32;
  localparam int unsigned G  = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned NG = W / G;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [NG-1:0] gc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_sub = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;
  logic [NG-1:0] out_gc;

  logic force_rdy = 1'b1;
  logic rand_rdy  = 1'b0;
  logic rnd_rdy   = 1'b1;
  assign out_ready = rand_rdy ? rnd_rdy : force_rdy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  cla_pipe_adder #(.WIDTH(W), .GROUP(G), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_gc(out_gc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [W-1:0] be;
    logic        c0;
    logic [W:0]  full;
    logic [63:0] m;
    logic [W:0]  part;
    be     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero = (e.sum == '0);
    for (int i = 0; i < NG; i++) begin
      m       = (64'd1 << (G * (i + 1))) - 64'd1;
      part    = {1'b0, a & m[W-1:0]} + {1'b0, be & m[W-1:0]} + {{W{1'b0}}, c0};
      e.gc[i] = part[G * (i + 1)];
    end
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input exp_t e);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout a=%h b=%h got in_ready=0 for 200 cycles, need 1", a, b);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    send(a, b, cin, sub, model(a, b, cin, sub));
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb_q.size() != 0; n++)
      @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d need 0", sb_q.size());
    end
  endtask

  // Monitor: compares on each transfer, and checks outputs stay stable while stalled.
  exp_t held;
  logic held_v = 1'b0;
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    got = '{sum: out_sum, cout: out_cout, ovf: out_ovf, zero: out_zero, gc: out_gc};
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        checks++;
        if (got != held) begin
          errors++;
          $display("FAIL hold got=%h need %h", got, held);
        end
      end
      held_v = out_valid && !out_ready;
      held   = got;
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got sum=%h, need no result", out_sum);
        end else begin
          e = sb_q.pop_front();
          if (got != e) begin
            errors++;
            $display("FAIL result got sum=%h cout=%b ovf=%b zero=%b gc=%h need sum=%h cout=%b ovf=%b zero=%b gc=%h",
                     got.sum, got.cout, got.ovf, got.zero, got.gc,
                     e.sum, e.cout, e.ovf, e.zero, e.gc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%h need %h", name, got, need);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_outputs", {out_sum, out_cout, out_ovf, out_zero, out_gc},
        {W+3+NG{1'b0}});
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Wrap add, with a latency check: accept at edge T, output after T+1
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1, gc: 8'hFF});
    chk("latency_t", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("latency_t1", {63'd0, out_valid}, 64'd1);
    drain();

    // Directed hand-computed vectors
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0, gc: 8'h7F});
    send(32'hF,         32'h1, 1'b0, 1'b0, '{sum: 32'h10,        cout: 1'b0, ovf: 1'b0, zero: 1'b0, gc: 8'h01});
    send(32'h5,         32'h7, 1'b0, 1'b1, '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0, gc: 8'h00});
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0, gc: 8'h80});
    send(32'h3,         32'h4, 1'b0, 1'b0, '{sum: 32'h7,         cout: 1'b0, ovf: 1'b0, zero: 1'b0, gc: 8'h00});
    send(32'h0,         32'h0, 1'b1, 1'b0, '{sum: 32'h1,         cout: 1'b0, ovf: 1'b0, zero: 1'b0, gc: 8'h00});
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1, gc: 8'hFF});
    send(32'h0,         32'h0, 1'b0, 1'b0, '{sum: 32'h0,         cout: 1'b0, ovf: 1'b0, zero: 1'b1, gc: 8'h00});
    send(32'h10,        32'h3, 1'b1, 1'b1, '{sum: 32'hD,         cout: 1'b1, ovf: 1'b0, zero: 1'b0, gc: 8'hFE});
    drain();

    // Backpressure: 8 beats, out_ready low for 4 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(W'(i), W'(i), 1'b0, 1'b0,
               '{sum: W'(2 * i), cout: 1'b0, ovf: 1'b0, zero: (i == 0), gc: 8'h00});
      end
      begin
        repeat (3) @(posedge clk);
        #1 force_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
        force_rdy = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    force_rdy = 1'b0;
    send_m(32'h11, 32'h22, 1'b0, 1'b0);
    send_m(32'h33, 32'h44, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_sum", {32'd0, out_sum}, 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    force_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
    send(32'h3, 32'h4, 1'b0, 1'b0, '{sum: 32'h7, cout: 1'b0, ovf: 1'b0, zero: 1'b0, gc: 8'h00});
    drain();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = '0;
        2: rb = ra;
        default: ;
      endcase
      send_m(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
